// File: rtl/swervolf_pkg.sv
// Shared SwerVolf constants for the GPIO input path.
// Defaults give a 1 ms debounce tick at the 50 MHz system clock.
package swervolf_pkg;

    localparam int unsigned GPIO_IN_W           = 64;
    localparam int unsigned CLK_HZ              = 50_000_000;
    localparam int unsigned GPIO_TICK_DEFAULT   = CLK_HZ / 1000;
    localparam int unsigned GPIO_STABLE_DEFAULT = 4;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/swervolf_debounce_bit.sv
// One GPIO input bit: synchroniser, tick-sampled debounce counter,
// debounced level flop and registered change pulse.
module swervolf_debounce_bit
    import swervolf_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STABLE      = GPIO_STABLE_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    input  logic i_tick,
    output logic o_level,
    output logic o_change,
    output logic o_change_next
);

    localparam int unsigned CW = $clog2(STABLE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   change_q, change_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], i_raw};
        cnt_d    = cnt_q;
        level_d  = level_q;
        change_d = 1'b0;
        if (i_tick) begin
            if (s == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                // New level has held for STABLE consecutive ticks: accept it.
                level_d  = s;
                cnt_d    = '0;
                change_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            change_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            change_q <= change_d;
        end
    end

    assign o_level       = level_q;
    assign o_change      = change_q;
    assign o_change_next = change_d;

endmodule

// File: rtl/swervolf_gpio_in.sv
// GPIO input conditioner: shared sample-tick prescaler, per-bit debounce
// and a registered change interrupt coincident with o_change.
module swervolf_gpio_in
    import swervolf_pkg::*;
#(
    parameter int unsigned WIDTH       = GPIO_IN_W,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PRESCALE    = GPIO_TICK_DEFAULT,
    parameter int unsigned STABLE      = GPIO_STABLE_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_gpio_raw,
    input  logic [WIDTH-1:0] i_irq_en,
    output logic [WIDTH-1:0] o_gpio,
    output logic [WIDTH-1:0] o_change,
    output logic             o_irq
);

    localparam int unsigned PW = cnt_width(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    pre_q, pre_d;
    logic             tick;
    logic [WIDTH-1:0] change_next;
    logic             irq_q, irq_d;

    // With PRESCALE == 1 the counter stays at 0 and tick is constantly high.
    assign tick = (pre_q == PRE_LAST);

    always_comb begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        irq_d = |(change_next & i_irq_en);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pre_q <= '0;
            irq_q <= 1'b0;
        end else begin
            pre_q <= pre_d;
            irq_q <= irq_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        swervolf_debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .STABLE      (STABLE)
        ) u_bit (
            .i_clk         (i_clk),
            .i_rst         (i_rst),
            .i_raw         (i_gpio_raw[i]),
            .i_tick        (tick),
            .o_level       (o_gpio[i]),
            .o_change      (o_change[i]),
            .o_change_next (change_next[i])
        );
    end

    assign o_irq = irq_q;

endmodule

// File: tb/tb_swervolf_gpio_in.sv
// Scoreboard bench for swervolf_gpio_in: a behavioural model predicts every
// cycle's outputs, a negedge monitor compares; directed scenarios add checks.
module tb_swervolf_gpio_in;

    localparam int W  = 64;
    localparam int SY = 2;
    localparam int P  = 4;
    localparam int ST = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] raw = '0;
    logic [W-1:0] en  = '0;
    logic [W-1:0] gpio;
    logic [W-1:0] chg;
    logic         irq;

    always #5 clk = ~clk;

    swervolf_gpio_in #(
        .WIDTH       (W),
        .SYNC_STAGES (SY),
        .PRESCALE    (P),
        .STABLE      (ST)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_gpio_raw (raw),
        .i_irq_en   (en),
        .o_gpio     (gpio),
        .o_change   (chg),
        .o_irq      (irq)
    );

    typedef struct packed {
        logic [W-1:0] gpio;
        logic [W-1:0] chg;
        logic         irq;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s @cycle %0d: got %h want %h", name, cyc, got, want);
    endtask

    // Reference model: raw level seen SY cycles late; every P-th cycle after
    // reset is a sample tick; a bit flips once it has differed from the
    // accepted level on ST consecutive ticks.
    logic [W-1:0] m_out;
    logic [W-1:0] m_hist[$];
    int           m_run[W];
    int           m_edges;

    task automatic model_edge();
        exp_t         e;
        logic [W-1:0] s;
        logic [W-1:0] tog;
        if (rst) begin
            m_out = '0;
            m_hist.delete();
            for (int k = 0; k < SY; k++) m_hist.push_back('0);
            for (int i = 0; i < W; i++) m_run[i] = 0;
            m_edges = 0;
            e = '0;
        end else begin
            s   = m_hist[SY-1];
            tog = '0;
            if (m_edges % P == P - 1) begin
                for (int i = 0; i < W; i++) begin
                    if (s[i] != m_out[i]) begin
                        m_run[i]++;
                        if (m_run[i] == ST) begin
                            tog[i]   = 1'b1;
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
            m_out = m_out ^ tog;
            m_hist.push_front(raw);
            void'(m_hist.pop_back());
            m_edges++;
            e.gpio = m_out;
            e.chg  = tog;
            e.irq  = |(tog & en);
        end
        sbq.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            check("sb_gpio", gpio, mon_e.gpio);
            check("sb_change", chg, mon_e.chg);
            check("sb_irq", 64'(irq), 64'(mon_e.irq));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int lat, c_a, c_b, c_i, coinc, g_any, idx;

    initial begin
        // 1: reset with all raw inputs high
        rst = 1'b1; raw = '1; en = '0;
        repeat (3) step();
        check("t1_rst_gpio", gpio, '0);
        check("t1_rst_change", chg, '0);
        rst = 1'b0;
        step();
        check("t1_first_gpio", gpio, '0);
        check("t1_first_change", chg, '0);
        check("t1_first_irq", 64'(irq), 64'd0);
        repeat (13) step();
        check("t1_settled_ones", gpio, '1);

        // 2: single rising bit with its interrupt enabled
        raw = '0;
        repeat (20) step();
        en = 64'h20; raw[5] = 1'b1;
        lat = -1; c_a = 0; c_i = 0; coinc = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (chg[5]) c_a++;
            if (irq) c_i++;
            if (lat < 0 && gpio[5]) begin
                lat   = k;
                coinc = int'(chg[5] & irq);
            end
        end
        check("t2_latency_window", 64'(lat >= 11 && lat <= 14), 64'd1);
        check("t2_change_pulses", 64'(c_a), 64'd1);
        check("t2_irq_pulses", 64'(c_i), 64'd1);
        check("t2_coincident", 64'(coinc), 64'd1);

        // 3: two-tick glitch is rejected
        en = 64'hA0; raw[7] = 1'b1;
        g_any = 0; c_a = 0; c_i = 0;
        for (int k = 0; k < 30; k++) begin
            if (k == 8) raw[7] = 1'b0;
            step();
            if (gpio[7]) g_any++;
            if (chg[7]) c_a++;
            if (irq) c_i++;
        end
        check("t3_gpio_quiet", 64'(g_any), 64'd0);
        check("t3_change_quiet", 64'(c_a), 64'd0);
        check("t3_irq_quiet", 64'(c_i), 64'd0);

        // 4: change pulse without interrupt enable
        en = '0; raw[9] = 1'b1;
        c_a = 0; c_i = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (chg[9]) c_a++;
            if (irq) c_i++;
        end
        check("t4_change_pulses", 64'(c_a), 64'd1);
        check("t4_irq_quiet", 64'(c_i), 64'd0);

        // 5: two bits changing together give one interrupt
        en = '1; raw[0] = 1'b1; raw[63] = 1'b1;
        c_a = 0; c_b = 0; c_i = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (chg[0] && chg[63]) c_a++;
            if (chg[0] || chg[63]) c_b++;
            if (irq) c_i++;
        end
        check("t5_joint_change", 64'(c_a), 64'd1);
        check("t5_change_cycles", 64'(c_b), 64'd1);
        check("t5_irq_pulses", 64'(c_i), 64'd1);

        // 6: reset mid-debounce discards the partial count
        raw[3] = 1'b1;
        repeat (8) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        g_any = 0; c_a = 0;
        for (int k = 1; k <= 11; k++) begin
            step();
            if (gpio[3]) g_any++;
            if (chg[3]) c_a++;
        end
        check("t6_gpio_early", 64'(g_any), 64'd0);
        check("t6_change_early", 64'(c_a), 64'd0);
        step();
        check("t6_gpio_rise", 64'(gpio[3]), 64'd1);
        check("t6_change_rise", 64'(chg[3]), 64'd1);

        // Random traffic against the model
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(7) == 0) begin
                idx = int'($urandom_range(W - 1));
                raw[idx] = ~raw[idx];
            end
            if ($urandom_range(63) == 0) en = {$urandom, $urandom};
            rst = ($urandom_range(399) == 0);
            step();
        end
        rst = 1'b0;
        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/swervolf_gpio_in.md
Name: swervolf_gpio_in

Overview:
- Input conditioner for the board GPIO inputs (switches, buttons). Sits directly upstream of the SoC controller's 64-bit GPIO input port.
- Synchronises each raw pin to i_clk and debounces it using a shared sample-tick prescaler.
- Emits per-bit change pulses and a maskable change interrupt.
- Its o_gpio connects directly to the controller's GPIO read input.

Parameters:
- WIDTH, 64, number of GPIO input bits.
- SYNC_STAGES, 2, synchroniser flops per bit (≥2).
- PRESCALE, 50000, i_clk cycles per debounce sample tick (≥1); the default gives a 1 ms tick at 50 MHz.
- STABLE, 4, number of consecutive ticks a new level must persist before it is accepted (≥1).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset. Synchronous, active-high.
- i_gpio_raw  in  WIDTH  asynchronous pin levels.
- i_irq_en  in  WIDTH  per-bit interrupt enable. Quasi-static, driven from a controller output register.
- o_gpio  out  WIDTH  debounced levels, fed to the controller's GPIO input.
- o_change  out  WIDTH  one-cycle pulse per bit when its o_gpio bit toggles.
- o_irq  out  1  one-cycle pulse when any enabled bit toggles.

Behaviour:
- Clock i_clk; reset i_rst, synchronous, active-high.
- Reset values:
  - All synchroniser flops = 0.
  - Prescaler = 0.
  - Every per-bit counter = 0.
  - o_gpio = 0, o_change = 0, o_irq = 0.
- Reset applied mid-debounce discards partial counts. No o_change or o_irq pulse occurs in the cycle after reset deasserts.
- Synchroniser: the raw bit passes through SYNC_STAGES flops; s[i] is the last stage.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps to 0.
  - tick = 1 in the cycle where the count equals PRESCALE-1.
  - With PRESCALE=1, tick is constant 1.
- Per-bit debounce. Registers: cnt[i], width $clog2(STABLE+1). Only evaluated when tick=1:
  - s[i] == o_gpio[i]: cnt[i] <= 0.
  - s[i] != o_gpio[i] and cnt[i] < STABLE-1: cnt[i] <= cnt[i]+1.
  - s[i] != o_gpio[i] and cnt[i] == STABLE-1: o_gpio[i] <= s[i], cnt[i] <= 0, and o_change[i] = 1 in the next cycle.
  - When tick=0: cnt[i] holds and o_change[i] = 0.
- o_change is registered and high for exactly one cycle, coincident with the cycle o_gpio updates.
- o_irq is registered and equals the OR over bits of (change_next & i_irq_en), so it is coincident with o_change.
  - Multiple bits changing in the same cycle produce a single o_irq pulse.
- Glitch rejection: a level that reverts before STABLE consecutive ticks resets cnt and causes no change on o_gpio.
- Latency from a stable raw edge to o_gpio:
  - Synchroniser: SYNC_STAGES cycles.
  - Debounce: STABLE ticks. Worst case adds up to PRESCALE-1 cycles of tick phase.
  - Bound: SYNC_STAGES+(STABLE-1)*PRESCALE+1 ≤ latency ≤ SYNC_STAGES+STABLE*PRESCALE.
- Bits are independent. No cross-bit ordering.
- Prescaler wrap has no side effects beyond tick.

Decomposition:
- Shared package swervolf_pkg holds:
  - GPIO_IN_W = 64.
  - Default tick constant CLK_HZ/1000.
  - Default STABLE.
- Natural sub-module: swervolf_debounce_bit, containing the synchroniser, cnt, the debounced flop and the change pulse for one bit. It takes tick as an input.
- Top level instantiates WIDTH copies via generate, plus the prescaler and the o_irq reduction.

Test Plan:
Bench uses WIDTH=64, SYNC_STAGES=2, PRESCALE=4, STABLE=3.
1. Assert i_rst with raw = all ones, then deassert -> o_gpio = 0, o_change = 0, o_irq = 0 during reset and in the first cycle after; o_gpio goes all ones within 2+12 cycles.
2. Raw[5] steps 0->1 and is held, i_irq_en[5]=1 -> o_gpio[5] rises between 2+9 and 2+12 cycles later; o_change[5] and o_irq each pulse for exactly 1 cycle in that same cycle.
3. Raw[7] goes high for 2 ticks (8 cycles) then low -> o_gpio[7], o_change[7] and o_irq stay 0 throughout.
4. Raw[9] toggles with i_irq_en = 0 -> o_change[9] pulses once; o_irq stays 0.
5. Raw[0] and raw[63] step high in the same cycle, enables = all ones -> both o_change bits pulse in the same cycle, with exactly one o_irq pulse.
6. Raw[3] goes high; i_rst is asserted for 1 cycle after 2 ticks, then raw[3] is held high -> no pulse tied to the earlier count; o_gpio[3] rises only after a full 3 ticks counted from reset release.
